division_restore: RTL and testbench

- Inverse-direction companion to the team's signed 16-bit divider.
- Takes a quotient, divisor and remainder triple and reconstructs the dividend as quotient*divisor + remainder.
- Sequential radix-2 shift-add multiplier with valid/ready handshakes on input and output.
- Sits downstream of the divider as a result-consistency checker, and as a general signed multiply-add unit.

---
 rtl/division_restore_pkg.sv | 22 ++
 rtl/division_restore_if.sv | 26 ++
 rtl/division_restore_umul_shift_add.sv | 60 ++++++
 rtl/division_restore.sv | 92 +++++++++
 tb/tb_division_restore.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/division_restore_pkg.sv
// Shared constants for the signed multiply-add (divider result restorer).
package division_restore_pkg;

  localparam int W  = 16;
  localparam int RW = 32;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Most negative W-bit signed value; shared with the divider bench.
  localparam logic signed [W-1:0] SMIN = 16'sh8000;

  // Magnitude of a W-bit two's complement value as unsigned W bits.
  // |SMIN| = 2^(W-1) still fits because the result is read as unsigned.
  function automatic logic [W-1:0] mag(input logic [W-1:0] x);
    return x[W-1] ? (~x + {{(W-1){1'b0}}, 1'b1}) : x;
  endfunction

endpackage

// File: rtl/division_restore_if.sv
// Operand/result handshake bundle for division_restore.
interface division_restore_if;
  import division_restore_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  din_q;
  logic [W-1:0]  din_b;
  logic [W-1:0]  din_r;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] dout;
  logic [W-1:0]  dout_w;
  logic          ovf;

  modport master (
    output in_valid, din_q, din_b, din_r, out_ready,
    input  in_ready, out_valid, dout, dout_w, ovf
  );

  modport slave (
    input  in_valid, din_q, din_b, din_r, out_ready,
    output in_ready, out_valid, dout, dout_w, ovf
  );

endinterface

// File: rtl/division_restore_umul_shift_add.sv
// Unsigned W x W radix-2 shift-add multiplier, one partial product per cycle.
module umul_shift_add
  import division_restore_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic          busy,
  output logic          last,
  output logic          done,
  output logic [RW-1:0] product
);

  localparam int CW = $clog2(W);

  logic [RW-1:0] acc;
  logic [RW-1:0] mcand;
  logic [W-1:0]  mplier;
  logic [CW-1:0] cnt;
  logic          busy_q;
  logic          done_q;

  // Load operands on start, then add/shift once per cycle for W cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        acc    <= '0;
        mcand  <= {{(RW-W){1'b0}}, a};
        mplier <= b;
        cnt    <= '0;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (cnt == CW'(W-1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy    = busy_q;
  assign last    = busy_q && (cnt == CW'(W-1));
  assign done    = done_q;
  assign product = acc;

endmodule

// File: rtl/division_restore.sv
// Reconstructs a signed dividend as q*b + r using an iterative unsigned
// multiplier; signs and the remainder are folded in during one fix-up cycle.
module division_restore
  import division_restore_pkg::*;
(
  input logic clk,
  input logic rst,
  division_restore_if.slave bus
);

  logic [1:0]    state;
  logic          sign_q;
  logic [RW-1:0] r_ext;
  logic [RW-1:0] dout_q;
  logic [W-1:0]  dout_w_q;
  logic          ovf_q;

  logic          mul_start;
  logic          mul_busy;
  logic          mul_last;
  logic          mul_done;
  logic [RW-1:0] mul_prod;

  logic [RW-1:0] signed_prod;
  logic [RW-1:0] fix_res;
  logic          fix_ovf;

  assign mul_start = (state == ST_IDLE) && bus.in_valid;

  umul_shift_add u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (mag(bus.din_q)),
    .b       (mag(bus.din_b)),
    .busy    (mul_busy),
    .last    (mul_last),
    .done    (mul_done),
    .product (mul_prod)
  );

  // Apply the product sign, add the remainder and flag results outside W-bit signed range.
  always_comb begin
    signed_prod = sign_q ? (~mul_prod + {{(RW-1){1'b0}}, 1'b1}) : mul_prod;
    fix_res     = signed_prod + r_ext;
    fix_ovf     = !((&fix_res[RW-1:W-1]) || !(|fix_res[RW-1:W-1]));
  end

  // Sequencing: accept, multiply, fix up, hold result until consumed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      sign_q   <= 1'b0;
      r_ext    <= '0;
      dout_q   <= '0;
      dout_w_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            sign_q <= bus.din_q[W-1] ^ bus.din_b[W-1];
            r_ext  <= {{(RW-W){bus.din_r[W-1]}}, bus.din_r};
            state  <= ST_MUL;
          end
        end
        ST_MUL: begin
          if (mul_busy && mul_last) state <= ST_FIX;
        end
        ST_FIX: begin
          if (mul_done) begin
            dout_q   <= fix_res;
            dout_w_q <= fix_res[W-1:0];
            ovf_q    <= fix_ovf;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.dout      = dout_q;
  assign bus.dout_w    = dout_w_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_division_restore.sv
// Bench for division_restore: directed corner cases, backpressure, reset
// during an operation, back-to-back issue and randomized operand triples.
module tb_division_restore;
  import division_restore_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  division_restore_if bus ();

  division_restore dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference: plain signed arithmetic on wide integers.
  function automatic void model(input logic [W-1:0] q, input logic [W-1:0] b,
                                input logic [W-1:0] r,
                                output logic [RW-1:0] d, output logic o);
    longint p;
    p = longint'($signed(q)) * longint'($signed(b)) + longint'($signed(r));
    d = p[RW-1:0];
    o = (p < -32768) || (p > 32767);
  endfunction

  // Presents a triple, lets it be accepted, scrambles the inputs, and
  // returns the number of edges until out_valid (0 if it never came).
  task automatic run_op(input logic [W-1:0] q, input logic [W-1:0] b,
                        input logic [W-1:0] r, output int lat);
    bus.din_q    = q;
    bus.din_b    = b;
    bus.din_r    = r;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.din_q    = 16'($urandom);
    bus.din_b    = 16'($urandom);
    bus.din_r    = 16'($urandom);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.din_q     = '0;
    bus.din_b     = '0;
    bus.din_r     = '0;
    rst = 1'b0;
    #22;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.dout !== '0 ||
        bus.dout_w !== '0 || bus.ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b dout=%h dout_w=%h ovf=%b, required 1 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.dout, bus.dout_w, bus.ovf);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_directed;
    logic [W-1:0]  tq [5];
    logic [W-1:0]  tb [5];
    logic [W-1:0]  tr [5];
    logic [RW-1:0] td [5];
    logic [W-1:0]  tw [5];
    logic          to [5];
    int lat;
    tq = '{16'd7, 16'hFFF9, 16'h8000, 16'd5, 16'h8000};
    tb = '{16'd3, 16'd3,    16'h8000, 16'd0, 16'd1};
    tr = '{16'd2, 16'hFFFE, 16'd0,    16'd9, 16'hFFFF};
    td = '{32'd23, 32'hFFFFFFE9, 32'h40000000, 32'd9, 32'hFFFF7FFF};
    tw = '{16'd23, 16'hFFE9, 16'h0000, 16'd9, 16'h7FFF};
    to = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      run_op(tq[k], tb[k], tr[k], lat);
      vectors++;
      if (lat !== 17) begin
        miscompares++;
        $display("FAIL directed_latency[%0d]: got %0d cycles, required 17", k, lat);
      end
      vectors++;
      if (bus.dout !== td[k] || bus.dout_w !== tw[k] || bus.ovf !== to[k]) begin
        miscompares++;
        $display("FAIL directed_result[%0d]: dout=%h dout_w=%h ovf=%b, required %h %h %b",
                 k, bus.dout, bus.dout_w, bus.ovf, td[k], tw[k], to[k]);
      end
      @(posedge clk); #1;
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL directed_handshake[%0d]: out_valid=%b in_ready=%b, required 0 1",
                 k, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [RW-1:0] ed;
    logic          eo;
    int lat;
    model(16'd1234, 16'hFFB3, 16'hFFFB, ed, eo);
    bus.out_ready = 1'b0;
    run_op(16'd1234, 16'hFFB3, 16'hFFFB, lat);
    vectors++;
    if (lat !== 17 || bus.dout !== ed || bus.ovf !== eo) begin
      miscompares++;
      $display("FAIL bp_result: lat=%0d dout=%h ovf=%b, required 17 %h %b", lat, bus.dout, bus.ovf, ed, eo);
    end
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1;
      bus.din_q    = 16'($urandom);
      bus.din_b    = 16'($urandom);
      bus.din_r    = 16'($urandom);
      @(posedge clk); #1;
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.dout !== ed ||
          bus.dout_w !== ed[W-1:0] || bus.ovf !== eo) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b dout=%h ovf=%b, required 1 0 %h %b",
                 k, bus.out_valid, bus.in_ready, bus.dout, bus.ovf, ed, eo);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.dout !== ed) begin
      miscompares++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b dout=%h, required 0 1 %h",
               bus.out_valid, bus.in_ready, bus.dout, ed);
    end
  endtask

  task automatic test_reset_mid_op;
    int lat;
    bus.out_ready = 1'b1;
    bus.din_q     = 16'd100;
    bus.din_b     = 16'd100;
    bus.din_r     = 16'd0;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.dout !== '0 || bus.in_ready !== 1'b1 || bus.ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_state: out_valid=%b dout=%h in_ready=%b ovf=%b, required 0 0 1 0",
               bus.out_valid, bus.dout, bus.in_ready, bus.ovf);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    run_op(16'd2, 16'd2, 16'd1, lat);
    vectors++;
    if (lat !== 17 || bus.dout !== 32'd5 || bus.ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_after: lat=%0d dout=%h ovf=%b, required 17 00000005 0", lat, bus.dout, bus.ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [RW-1:0] ea, eb;
    logic          oa, ob;
    int lat;
    int gap;
    model(16'd300, 16'hFF00, 16'd77, ea, oa);
    model(16'hFFFF, 16'hFFFF, 16'h8000, eb, ob);
    bus.out_ready = 1'b1;
    bus.din_q     = 16'd300;
    bus.din_b     = 16'hFF00;
    bus.din_r     = 16'd77;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.din_q = 16'hFFFF;
    bus.din_b = 16'hFFFF;
    bus.din_r = 16'h8000;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
    vectors++;
    if (lat !== 17 || bus.dout !== ea || bus.ovf !== oa) begin
      miscompares++;
      $display("FAIL b2b_first: lat=%0d dout=%h ovf=%b, required 17 %h %b", lat, bus.dout, bus.ovf, ea, oa);
    end
    gap = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        gap = i;
        break;
      end
    end
    bus.in_valid = 1'b0;
    vectors++;
    if (gap !== 19 || bus.dout !== eb || bus.ovf !== ob) begin
      miscompares++;
      $display("FAIL b2b_second: gap=%0d dout=%h ovf=%b, required 19 %h %b", gap, bus.dout, bus.ovf, eb, ob);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    logic [W-1:0]  corner [5];
    logic [W-1:0]  q, b, r;
    logic [RW-1:0] ed;
    logic          eo;
    int lat;
    corner = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000, 16'h0001};
    bus.out_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      q = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 16'($urandom);
      r = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 16'($urandom);
      model(q, b, r, ed, eo);
      run_op(q, b, r, lat);
      vectors++;
      if (lat !== 17 || bus.dout !== ed || bus.dout_w !== ed[W-1:0] || bus.ovf !== eo) begin
        miscompares++;
        $display("FAIL random[%0d] q=%h b=%h r=%h: lat=%0d dout=%h dout_w=%h ovf=%b, required 17 %h %h %b",
                 k, q, b, r, lat, bus.dout, bus.dout_w, bus.ovf, ed, ed[W-1:0], eo);
      end
      @(posedge clk); #1;
      vectors++;
      if (bus.in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL random_ready[%0d]: in_ready=%b, required 1", k, bus.in_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
